lsu_mem_stage: RTL and testbench

- Memory-stage load/store unit of the RISC-V datapath.
- Accepts one load/store request at a time and runs the data-memory handshake.
- Aligns and sign- or zero-extends load data, then registers a single-cycle writeback result.
- Its output is consumed directly by the 8-way writeback select mux.

---
 rtl/lsu_mem_stage.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one request at a time, data-memory handshake,
// load alignment/extension and a registered single-cycle writeback result.
module lsu_mem_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [width-1:0] req_addr,
  input  logic [width-1:0] req_wdata,
  input  logic [4:0]       req_rd,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [width-1:0] dmem_addr,
  output logic [3:0]       dmem_wmask,
  output logic [width-1:0] dmem_wdata,
  input  logic             dmem_resp,
  input  logic [width-1:0] dmem_rdata,
  output logic             done,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [width-1:0] wb_data,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

  state_t     state;
  logic [2:0] funct3_reg;
  logic [1:0] addr_lo_reg;
  logic [4:0] rd_reg;
  logic       load_reg;

  logic             legal;
  logic [3:0]       fmt_mask;
  logic [width-1:0] fmt_wdata;
  logic [7:0]       lane [4];
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [width-1:0] load_fmt;

  // Legality covers funct3, load/store exclusivity and natural alignment.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = req_load;
      3'b101:  legal = req_load & ~req_addr[0];
      default: legal = 1'b0;
    endcase
    if (req_load && req_store)
      legal = 1'b0;
  end

  always_comb begin
    fmt_mask  = 4'b1111;
    fmt_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        fmt_mask  = 4'b0001 << req_addr[1:0];
        fmt_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        fmt_mask  = 4'b0011 << {req_addr[1], 1'b0};
        fmt_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        fmt_mask  = 4'b1111;
        fmt_wdata = req_wdata;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = dmem_rdata[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo_reg];
  assign half_sel = addr_lo_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_fmt = '0;
    case (funct3_reg)
      3'b000:  load_fmt = {{(width-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{(width-16){half_sel[15]}}, half_sel};
      3'b010:  load_fmt = dmem_rdata;
      3'b100:  load_fmt = {{(width-8){1'b0}}, byte_sel};
      3'b101:  load_fmt = {{(width-16){1'b0}}, half_sel};
      default: load_fmt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      funct3_reg  <= '0;
      addr_lo_reg <= '0;
      rd_reg      <= '0;
      load_reg    <= 1'b0;
      req_ready   <= 1'b1;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      dmem_addr   <= '0;
      dmem_wmask  <= '0;
      dmem_wdata  <= '0;
      done        <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A request with neither kind set is consumed silently.
          if (req_valid && (req_load || req_store)) begin
            funct3_reg  <= req_funct3;
            addr_lo_reg <= req_addr[1:0];
            rd_reg      <= req_rd;
            load_reg    <= req_load;
            req_ready   <= 1'b0;
            if (legal) begin
              dmem_addr  <= {req_addr[width-1:2], 2'b00};
              dmem_read  <= req_load;
              dmem_write <= req_store;
              dmem_wmask <= req_store ? fmt_mask : 4'b0000;
              dmem_wdata <= req_store ? fmt_wdata : '0;
              state      <= ACCESS;
            end else begin
              done    <= 1'b1;
              err     <= 1'b1;
              wb_we   <= 1'b0;
              wb_rd   <= req_rd;
              wb_data <= '0;
              state   <= FINISH;
            end
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            done       <= 1'b1;
            wb_we      <= load_reg && (rd_reg != 5'd0);
            wb_rd      <= rd_reg;
            wb_data    <= load_reg ? load_fmt : '0;
            state      <= FINISH;
          end
        end
        FINISH: begin
          done      <= 1'b0;
          err       <= 1'b0;
          wb_we     <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: loads, stores, illegal requests,
// back-pressure while busy and asynchronous reset mid-access.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        done, wb_we, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns just after that edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    step();
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
  endtask

  // Zero-wait load: response in the first ACCESS cycle.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [31:0] exp_data, input logic exp_we);
    issue(1'b1, 1'b0, f3, addr, 32'h0, rd);
    chk({tag, ".read"}, {31'b0, dmem_read}, 32'd1);
    chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
    dmem_resp = 1'b1; dmem_rdata = rdata;
    step();
    dmem_resp = 1'b0;
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    chk({tag, ".we"}, {31'b0, wb_we}, {31'b0, exp_we});
    chk({tag, ".data"}, wb_data, exp_data);
    chk({tag, ".rd"}, {27'b0, wb_rd}, {27'b0, rd});
    $display("txn %s addr=0x%08h rdata=0x%08h -> wb_data=0x%08h wb_we=%0b", tag, addr, rdata, wb_data, wb_we);
    step();
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] exp_mask, input logic [31:0] exp_wd);
    issue(1'b0, 1'b1, f3, addr, wd, 5'd3);
    chk({tag, ".write"}, {31'b0, dmem_write}, 32'd1);
    chk({tag, ".read"}, {31'b0, dmem_read}, 32'd0);
    chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, ".mask"}, {28'b0, dmem_wmask}, {28'b0, exp_mask});
    chk({tag, ".wdata"}, dmem_wdata, exp_wd);
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    chk({tag, ".we"}, {31'b0, wb_we}, 32'd0);
    chk({tag, ".wr_drop"}, {31'b0, dmem_write}, 32'd0);
    $display("txn %s addr=0x%08h mask=%04b wdata=0x%08h", tag, addr, exp_mask, exp_wd);
    step();
  endtask

  task automatic run_illegal(input string tag, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] addr);
    issue(ld, st, f3, addr, 32'h0, 5'd9);
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    chk({tag, ".err"}, {31'b0, err}, 32'd1);
    chk({tag, ".we"}, {31'b0, wb_we}, 32'd0);
    chk({tag, ".nostrobe"}, {30'b0, dmem_read, dmem_write}, 32'd0);
    if (ld && !st) chk({tag, ".data"}, wb_data, 32'd0);
    $display("txn %s illegal addr=0x%08h f3=%03b", tag, addr, f3);
    step();
    chk({tag, ".clr"}, {30'b0, done, err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    dmem_resp = 1'b0; dmem_rdata = '0;
    step(); step();
    chk("rst.ready", {31'b0, req_ready}, 32'd1);
    chk("rst.strobes", {30'b0, dmem_read, dmem_write}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.mask", {28'b0, dmem_wmask}, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.flags", {29'b0, done, wb_we, err}, 32'd0);
    chk("rst.wb", wb_data, 32'd0);
    chk("rst.wbrd", {27'b0, wb_rd}, 32'd0);
    rst_n = 1'b1;
    step();

    // lw with one wait cycle: read held for two cycles.
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
    chk("lw.read1", {31'b0, dmem_read}, 32'd1);
    chk("lw.addr", dmem_addr, 32'h100);
    chk("lw.busy", {31'b0, req_ready}, 32'd0);
    step();
    chk("lw.read2", {31'b0, dmem_read}, 32'd1);
    chk("lw.nodone", {31'b0, done}, 32'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_resp = 1'b0;
    chk("lw.done", {31'b0, done}, 32'd1);
    chk("lw.we", {31'b0, wb_we}, 32'd1);
    chk("lw.rd", {27'b0, wb_rd}, 32'd5);
    chk("lw.data", wb_data, 32'hDEADBEEF);
    chk("lw.rddrop", {31'b0, dmem_read}, 32'd0);
    chk("lw.err", {31'b0, err}, 32'd0);
    $display("txn lw addr=0x00000100 -> wb_data=0x%08h", wb_data);
    step();
    chk("lw.pulse", {31'b0, done}, 32'd0);
    chk("lw.ready", {31'b0, req_ready}, 32'd1);

    run_load("lb", 3'b000, 32'h103, 32'h80FF1234, 5'd6, 32'hFFFFFF80, 1'b1);
    run_load("lbu", 3'b100, 32'h103, 32'h80FF1234, 5'd6, 32'h00000080, 1'b1);
    run_load("lb0", 3'b000, 32'h101, 32'h80FF1234, 5'd6, 32'h00000012, 1'b1);
    run_load("lh", 3'b001, 32'h102, 32'h9ABC0000, 5'd7, 32'hFFFF9ABC, 1'b1);
    run_load("lhu", 3'b101, 32'h102, 32'h9ABC0000, 5'd7, 32'h00009ABC, 1'b1);
    run_load("lhlo", 3'b001, 32'h100, 32'h00008001, 5'd8, 32'hFFFF8001, 1'b1);
    run_load("lwr0", 3'b010, 32'h104, 32'h11223344, 5'd0, 32'h11223344, 1'b0);

    run_store("sb", 3'b000, 32'h201, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    run_store("sh", 3'b001, 32'h202, 32'h00001234, 4'b1100, 32'h12341234);
    run_store("sw", 3'b010, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    run_illegal("lh_mis", 1'b1, 1'b0, 3'b001, 32'h101);
    run_illegal("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102);
    run_illegal("f3_011", 1'b1, 1'b0, 3'b011, 32'h100);
    run_illegal("sbu", 1'b0, 1'b1, 3'b100, 32'h100);
    run_illegal("ldst", 1'b1, 1'b1, 3'b010, 32'h100);

    // Neither load nor store: consumed without done.
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd4);
    chk("nop.ready", {31'b0, req_ready}, 32'd1);
    chk("nop.quiet", {29'b0, done, dmem_read, dmem_write}, 32'd0);
    step();
    chk("nop.nodone", {31'b0, done}, 32'd0);
    $display("txn nop consumed");

    // Request held while busy is not taken.
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd10);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h300;
    chk("busy.ready", {31'b0, req_ready}, 32'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h0;
    step();
    dmem_resp = 1'b0;
    chk("busy.ready_fin", {31'b0, req_ready}, 32'd0);
    chk("busy.nowrite", {31'b0, dmem_write}, 32'd0);
    req_valid = 1'b0; req_store = 1'b0;
    step();
    chk("busy.idle", {31'b0, req_ready}, 32'd1);
    step();
    chk("busy.notaken", {30'b0, dmem_write, done}, 32'd0);
    $display("txn busy request ignored");

    // Asynchronous reset mid-access; late response must be ignored.
    issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd11);
    chk("arst.read", {31'b0, dmem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.drop", {31'b0, dmem_read}, 32'd0);
    chk("arst.ready", {31'b0, req_ready}, 32'd1);
    chk("arst.addr", dmem_addr, 32'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h55AA55AA;
    #2 rst_n = 1'b1;
    step();
    chk("arst.nodone1", {31'b0, done}, 32'd0);
    chk("arst.ready2", {31'b0, req_ready}, 32'd1);
    step();
    dmem_resp = 1'b0;
    chk("arst.nodone2", {30'b0, done, wb_we}, 32'd0);
    chk("arst.wb", wb_data, 32'd0);
    $display("txn async reset during access");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
